// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StApply = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Bits needed to count 0..value-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// Counts the cycles a vector is held; tick marks the last cycle of each window.
module hold_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned HOLD = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = clog2(HOLD);
  localparam logic [W-1:0] Last = W'(HOLD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a combinational DUT, compares its output with
// an expected truth table and reports error count, first failure and pass.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned          N_IN   = 4,
  parameter int unsigned          HOLD   = 20,
  parameter logic [(1<<N_IN)-1:0] EXPECT = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_f,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail_idx
);

  localparam logic [N_IN-1:0] LastIdx = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] first_q, first_d;
  logic            fail_q, fail_d;
  logic            accept;
  logic            tick;
  logic            mismatch;

  assign accept   = start && (state_q != StApply);
  assign mismatch = (dut_f != EXPECT[vec_q]);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (state_q == StApply),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    first_d = first_q;
    fail_d  = fail_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StApply;
          vec_d   = '0;
          err_d   = '0;
          first_d = '0;
          fail_d  = 1'b0;
        end
      end
      StApply: begin
        if (tick) begin
          // Compare uses the registered index, i.e. the vector actually applied.
          if (mismatch) begin
            err_d = err_q + (N_IN + 1)'(1);
            if (!fail_q) begin
              first_d = vec_q;
              fail_d  = 1'b1;
            end
          end
          if (vec_q == LastIdx) state_d = StDone;
          else                  vec_d   = vec_q + N_IN'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      first_q <= first_d;
      fail_q  <= fail_d;
    end
  end

  assign vec_out        = vec_q;
  assign busy           = (state_q == StApply);
  assign done           = (state_q == StDone);
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign fail_valid     = fail_q;
  assign first_fail_idx = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: a 4-input sweep against golden and
// faulty DUT models, a sweep disturbed by start/reset, and a 2-input corner.
module tb_truth_table_sweeper;

  localparam logic [15:0] ExpA = 16'hA5C3;
  localparam logic [3:0]  ExpB = 4'b1000;

  typedef struct packed {
    logic [4:0] err;
    logic [3:0] first;
    logic       fv;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] vec_a, first_a;
  logic [4:0] err_a;
  logic       busy_a, done_a, pass_a, fv_a, f_a;
  logic [1:0] vec_b, first_b;
  logic [2:0] err_b;
  logic       busy_b, done_b, pass_b, fv_b, f_b;
  int         mode = 0;  // 0 golden, 1 stuck-at-0, 2 inverted at vector 9
  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;

  always_comb begin
    f_a = ExpA[vec_a];
    if (mode == 1) f_a = 1'b0;
    else if (mode == 2 && vec_a == 4'd9) f_a = ~ExpA[vec_a];
  end

  assign f_b = vec_b[1] & vec_b[0];

  truth_table_sweeper #(
    .N_IN   (4),
    .HOLD   (20),
    .EXPECT (ExpA)
  ) u_dut_a (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_a),
    .vec_out        (vec_a),
    .dut_f          (f_a),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .err_count      (err_a),
    .fail_valid     (fv_a),
    .first_fail_idx (first_a)
  );

  truth_table_sweeper #(
    .N_IN   (2),
    .HOLD   (2),
    .EXPECT (ExpB)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start_b),
    .vec_out        (vec_b),
    .dut_f          (f_b),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .err_count      (err_b),
    .fail_valid     (fv_b),
    .first_fail_idx (first_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_vec"}, vec_a, 0);
    chk({tag, "_err"}, err_a, 0);
    chk({tag, "_fv"}, fv_a, 0);
    chk({tag, "_first"}, first_a, 0);
  endtask

  // Called on a negedge; the next posedge is the start edge.
  task automatic sweep_a(input exp_t e);
    int   k;
    exp_t got;
    sb.push_back(e);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy_at_start", busy_a, 1);
    chk("a_done_at_start", done_a, 0);
    chk("a_err_at_start", err_a, 0);
    k = 0;
    while (!done_a && k < 400) begin
      chk("a_vec_step", vec_a, k / 20);
      @(negedge clk);
      k++;
    end
    chk("a_latency", k, 320);
    got = sb.pop_front();
    chk("a_err_count", err_a, got.err);
    chk("a_first_fail", first_a, got.first);
    chk("a_fail_valid", fv_a, got.fv);
    chk("a_pass", pass_a, got.pass);
    chk("a_busy_done", busy_a, 0);
  endtask

  task automatic sweep_b();
    int k;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_busy_at_start", busy_b, 1);
    chk("b_done_at_start", done_b, 0);
    k = 0;
    while (!done_b && k < 40) begin
      chk("b_vec_step", vec_b, k / 2);
      @(negedge clk);
      k++;
    end
    chk("b_latency", k, 8);
    chk("b_pass", pass_b, 1);
    chk("b_err_count", err_b, 0);
    chk("b_fail_valid", fv_b, 0);
  endtask

  initial begin
    // Reset held 3 cycles with start asserted: start must be ignored.
    start_a = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle_a("rst");
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_done", done_b, 0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_a("post_rst");

    mode = 0;
    sweep_a('{err: 5'd0, first: 4'd0, fv: 1'b0, pass: 1'b1});
    mode = 1;
    sweep_a('{err: 5'd8, first: 4'd0, fv: 1'b1, pass: 1'b0});
    mode = 2;
    sweep_a('{err: 5'd1, first: 4'd9, fv: 1'b1, pass: 1'b0});

    // Disturbed sweep: extra start at vector 3, reset at vector 5.
    mode = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (65) @(negedge clk);
    chk("dist_vec3", vec_a, 3);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("dist_busy_after_start", busy_a, 1);
    chk("dist_vec_after_start", vec_a, 3);
    repeat (19) @(negedge clk);
    chk("dist_vec4", vec_a, 4);
    repeat (20) @(negedge clk);
    chk("dist_vec5", vec_a, 5);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle_a("dist_rst");
    repeat (3) @(negedge clk);
    chk_idle_a("dist_idle");
    sweep_a('{err: 5'd0, first: 4'd0, fv: 1'b0, pass: 1'b1});

    // Corner: two inputs, minimum hold, rerun from DONE.
    sweep_b();
    repeat (2) @(negedge clk);
    chk("b_done_held", done_b, 1);
    sweep_b();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-contained sequential stimulus/checker engine for combinational DUTs with N_IN inputs and one output.
- On start, sweeps all 2^N_IN input vectors in ascending binary order and holds each for HOLD cycles.
- Samples the DUT output at the end of each hold window and compares it against a parameterised expected truth table.
- Reports an error count, the first failing index, and pass/done.
- Sits beside the DUT in a bench or on-chip BIST wrapper, replacing hand-written vector lists.

Parameters:
- N_IN, 4, number of DUT inputs (1..8).
- HOLD, 20, clock cycles each vector is held (>=2).
- EXPECT, 16'h0000, expected output truth table, 2^N_IN bits; bit i = expected f for vector i.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse, begins a sweep; honoured only in IDLE or DONE.
- vec_out  out  N_IN  vector driven to DUT inputs; MSB = first DUT input (a).
- dut_f  in  1  DUT output under test.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high in DONE state until the next start or reset.
- pass  out  1  valid when done; 1 iff err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors (max 2^N_IN; no saturation needed).
- fail_valid  out  1  a mismatch has been recorded this sweep.
- first_fail_idx  out  N_IN  index of the first mismatching vector; held once fail_valid=1.

Behaviour:
- One clock; reset is synchronous and active-low.
- rst_n=0 at a rising edge forces, on that edge:
  - state=IDLE;
  - vec_out, err_count and first_fail_idx to 0;
  - busy, done, pass and fail_valid to 0.
- Reset has priority over start. A reset mid-sweep aborts immediately, with no partial results retained.
- States: IDLE, APPLY, DONE.
- IDLE/DONE + start=1: at that edge go to APPLY, with:
  - idx=0, vec_out=0, hold_cnt=0, busy=1, done=0, pass=0;
  - err_count=0, fail_valid=0, first_fail_idx=0.
- APPLY:
  - hold_cnt increments each cycle.
  - At the edge where hold_cnt==HOLD-1, dut_f is sampled and compared with EXPECT[idx].
  - On mismatch: err_count increments. If fail_valid=0, first_fail_idx<=idx and fail_valid<=1.
  - If idx==2^N_IN-1, go to DONE. Otherwise idx increments, vec_out<=idx+1 and hold_cnt<=0.
- vec_out always equals idx and changes only on a sample edge, so the DUT has HOLD-1 cycles to settle before sampling.
- DONE: busy=0, done=1, and pass=(err_count==0), with the final mismatch included.
- start during APPLY is ignored; there is no restart mid-sweep.
- Latency: done rises exactly 2^N_IN*HOLD cycles after the start edge. For the defaults this is 320 cycles.
- The compare uses the registered idx, never the next value. Wrap of idx past the last vector does not occur: the state leaves APPLY first.
- dut_f is assumed synchronous to clk or settled; no synchroniser is included.

Decomposition:
- Shared package/header holds:
  - state encoding localparams (IDLE=2'd0, APPLY=2'd1, DONE=2'd2);
  - a clog2 helper function for sizing hold_cnt.
- One natural sub-module, hold_timer:
  - parameter HOLD, with inputs clk, rst_n, clear, en;
  - output tick, pulsed on the last hold cycle.
- The top-level FSM, index counter and scoreboard registers stay in truth_table_sweeper.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0, state IDLE; start while rst_n=0 is ignored.
- Golden DUT model with f=EXPECT[vec], EXPECT=16'hA5C3, N_IN=4, HOLD=20:
  - expect done at start+320 cycles;
  - pass=1, err_count=0, fail_valid=0;
  - vec_out steps 0..15, changing every 20 cycles.
- Stuck-at-0 DUT with EXPECT=16'hA5C3 -> err_count=8, first_fail_idx=0, fail_valid=1, pass=0.
- Golden model with output inverted only at vector 9 -> err_count=1, first_fail_idx=9, pass=0.
- Sweep disturbance: pulse start again at vector 3, then drop rst_n for one cycle at vector 5:
  - expect the second start to be ignored;
  - expect IDLE with vec_out=0 after reset;
  - a fresh start restarts from vector 0 and completes in 320 cycles.
- Corner N_IN=2, HOLD=2, EXPECT=4'b1000 with a golden AND DUT:
  - done after 8 cycles, pass=1;
  - a second start from DONE clears done and reruns identically.
